// File: rtl/alu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// alu_rr_arbiter
//
// Shares one combinational ALU among NREQ requesters. One request at a time is
// accepted with a valid/ready handshake. The grant goes round-robin, starting
// the search at the requester after the one granted last. The accepted op runs
// on the ALU for one cycle. The result is then held in a response register
// until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]      per-requester request valid
//   req_ready  [NREQ]      per-requester accept (one-hot or zero)
//   req_op     [4*NREQ]    opcode per requester, slice i = [4i+3:4i]
//   req_a      [DW*NREQ]   operand 1 per requester
//   req_b      [DW*NREQ]   operand 2 per requester
//   alu_en     ALU enable (legal op in EXEC only)
//   alu_op     [4]         ALU opcode (latched)
//   alu_in1    [DW]        ALU operand 1 (latched)
//   alu_in2    [DW]        ALU operand 2 (latched)
//   alu_out    [DW]        ALU result, combinational from alu_* outputs
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     [IDW]       index of the requester that issued the op
//   rsp_data   [DW]        result (0 for an illegal op)
//   rsp_err    opcode was illegal (1000..1111)
// ----------------------------------------------------------------------------
module alu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [4*NREQ-1:0]    req_op,
    input  logic [DW*NREQ-1:0]   req_a,
    input  logic [DW*NREQ-1:0]   req_b,
    output logic                 alu_en,
    output logic [3:0]           alu_op,
    output logic [DW-1:0]        alu_in1,
    output logic [DW-1:0]        alu_in2,
    input  logic [DW-1:0]        alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_data,
    output logic                 rsp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [3:0]      r_op;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [IDW-1:0]  r_gid;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;

    logic            w_any;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_first;
    logic [NREQ-1:0] w_gnt_oh;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_next_ptr;
    logic [3:0]      w_sel_op;
    logic [DW-1:0]   w_sel_a;
    logic [DW-1:0]   w_sel_b;
    logic            w_illegal;

    // Round-robin search without variable bit-selects: rotate the valids so
    // that bit 0 is the requester at r_rr_ptr, isolate the lowest set bit,
    // then rotate that one-hot back into requester order.
    always_comb begin
        w_any    = |req_valid;
        w_rot    = NREQ'({req_valid, req_valid} >> r_rr_ptr);
        w_first  = w_rot & ~(w_rot - NREQ'(1));
        w_gnt_oh = NREQ'(({w_first, w_first} << r_rr_ptr) >> NREQ);
    end

    // One-hot grant to index, and the operand mux for the granted requester.
    always_comb begin
        w_grant  = '0;
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (w_gnt_oh == (NREQ'(1) << k)) begin
                w_grant  = IDW'(k);
                w_sel_op = 4'(req_op >> (4 * k));
                w_sel_a  = DW'(req_a >> (DW * k));
                w_sel_b  = DW'(req_b >> (DW * k));
            end
        end
    end

    assign w_next_ptr = (w_grant == IDW'(NREQ - 1)) ? '0 : w_grant + IDW'(1);
    assign w_illegal  = r_op[3];

    assign req_ready = (r_state == S_IDLE && w_any) ? w_gnt_oh : '0;
    assign alu_en    = (r_state == S_EXEC) && !w_illegal;
    assign alu_op    = r_op;
    assign alu_in1   = r_a;
    assign alu_in2   = r_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_gid       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op     <= w_sel_op;
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_gid    <= w_grant;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_id    <= r_gid;
                    r_rsp_valid <= 1'b1;
                    if (w_illegal) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end else begin
                        r_rsp_data <= alu_out;
                        r_rsp_err  <= 1'b0;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for alu_rr_arbiter. A behavioural ALU stub closes the alu_* loop.
// The reference model tracks the arbiter as a round-robin pointer plus cycle
// arithmetic: accept at T, EXEC at T+1, response from T+2 until it is taken.
// Expected responses go into a scoreboard queue. A separate monitor checks
// and pops that queue whenever the DUT presents a response.
// ----------------------------------------------------------------------------
module tb_alu_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [DW*NREQ-1:0]  req_a;
    logic [DW*NREQ-1:0]  req_b;
    logic                alu_en;
    logic [3:0]          alu_op;
    logic [DW-1:0]       alu_in1;
    logic [DW-1:0]       alu_in2;
    logic [DW-1:0]       alu_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    // 0 add, 1 sub, 2 mul, 3 shl, 4 shr, 5 and, 6 or, 7 unsigned less-than
    function automatic logic [DW-1:0] alu_ref(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return a << b[4:0];
            4'd4: return a >> b[4:0];
            4'd5: return a & b;
            4'd6: return a | b;
            4'd7: return (a < b) ? DW'(1) : '0;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic           err;
    } rsp_t;

    rsp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    int              m_ptr  = 0;
    bit              m_busy = 1'b0;
    int              m_tacc = 0;
    logic [3:0]      m_op;
    logic [DW-1:0]   m_a;
    logic [DW-1:0]   m_b;
    bit              exp_rv;
    bit              exp_en;
    bit              granted;
    int              gsel;
    logic [NREQ-1:0] exp_ready;
    rsp_t            e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            check("reset_req_ready", 64'(req_ready), 64'(0));
            check("reset_alu_en",    64'(alu_en),    64'(0));
            check("reset_alu_op",    64'(alu_op),    64'(0));
            check("reset_alu_in1",   64'(alu_in1),   64'(0));
            check("reset_alu_in2",   64'(alu_in2),   64'(0));
            check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
            check("reset_rsp_id",    64'(rsp_id),    64'(0));
            check("reset_rsp_data",  64'(rsp_data),  64'(0));
            check("reset_rsp_err",   64'(rsp_err),   64'(0));
            m_busy = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else begin
            exp_rv = m_busy && (cyc >= m_tacc + 2);
            exp_en = m_busy && (cyc == m_tacc + 1) && (m_op < 4'd8);
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("alu_en",    64'(alu_en),    64'(exp_en));
            if (m_busy && cyc == m_tacc + 1) begin
                check("exec_alu_op",  64'(alu_op),  64'(m_op));
                check("exec_alu_in1", 64'(alu_in1), 64'(m_a));
                check("exec_alu_in2", 64'(alu_in2), 64'(m_b));
            end

            exp_ready = '0;
            granted   = 1'b0;
            gsel      = 0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!granted && 1'((req_valid >> ((m_ptr + k) % NREQ))) != 1'b0) begin
                        granted = 1'b1;
                        gsel    = (m_ptr + k) % NREQ;
                    end
                end
            end
            if (granted) begin
                exp_ready = NREQ'(1) << gsel;
                m_op   = 4'(req_op >> (4 * gsel));
                m_a    = DW'(req_a >> (DW * gsel));
                m_b    = DW'(req_b >> (DW * gsel));
                e.id   = IDW'(gsel);
                e.err  = (m_op >= 4'd8);
                e.data = e.err ? '0 : alu_ref(m_op, m_a, m_b);
                sb_q.push_back(e);
                m_tacc = cyc;
                m_ptr  = (gsel + 1) % NREQ;
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));

            if (exp_rv && rsp_ready) m_busy = 1'b0;
            if (granted) m_busy = 1'b1;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0d, want no response (cycle %0d)",
                         rsp_id, rsp_data, rsp_err, cyc);
            end else begin
                check("rsp_id",   64'(rsp_id),   64'(sb_q[0].id));
                check("rsp_data", 64'(rsp_data), 64'(sb_q[0].data));
                check("rsp_err",  64'(rsp_err),  64'(sb_q[0].err));
                if (rsp_ready) void'(sb_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] op,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid = (req_valid & ~(NREQ'(1) << i)) | (NREQ'(v) << i);
        req_op    = (req_op & ~((4*NREQ)'(4'hF) << (4 * i))) | ((4*NREQ)'(op) << (4 * i));
        req_a     = (req_a & ~((DW*NREQ)'({DW{1'b1}}) << (DW * i))) | ((DW*NREQ)'(a) << (DW * i));
        req_b     = (req_b & ~((DW*NREQ)'({DW{1'b1}}) << (DW * i))) | ((DW*NREQ)'(b) << (DW * i));
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    int unsigned t;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        idle(2);

        // single request from requester 1: 5 + 7
        set_req(1, 1'b1, 4'd0, 32'd5, 32'd7);
        step();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        idle(5);

        // requester 2 accepted, then reset lands in its EXEC cycle
        set_req(2, 1'b1, 4'd0, 32'd100, 32'd200);
        step();
        set_req(2, 1'b0, 4'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        idle(3);

        // all four continuously valid: grant order restarts from 0
        set_req(0, 1'b1, 4'd1, 32'd10, 32'd3);
        set_req(1, 1'b1, 4'd2, 32'd3,  32'd4);
        set_req(2, 1'b1, 4'd3, 32'd1,  32'd4);
        set_req(3, 1'b1, 4'd7, 32'd2,  32'd5);
        repeat (15) step();
        idle(5);

        // backpressure with a competing request pending; add wraps to 1
        set_req(0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd2);
        rsp_ready = 1'b0;
        step();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
        repeat (8) step();
        rsp_ready = 1'b1;
        repeat (6) step();
        idle(5);

        // illegal opcode from requester 2 (leaves the pointer at 3)
        set_req(2, 1'b1, 4'b1010, 32'd9, 32'd9);
        step();
        set_req(2, 1'b0, 4'd0, 32'd0, 32'd0);
        idle(5);

        // pointer at 3 with only requesters 0 and 1 valid: 0 then 1
        set_req(0, 1'b1, 4'd6, 32'h0000_00F0, 32'h0000_000F);
        set_req(1, 1'b1, 4'd4, 32'd256,       32'd4);
        repeat (8) step();
        idle(5);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                t = $urandom_range(0, 9);
                set_req(i, bit'($urandom_range(0, 1)),
                        (t < 8) ? 4'(t) : 4'(8 + $urandom_range(0, 7)),
                        $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        idle(8);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU among NREQ requesters, e.g. neighbouring PE ports or a config loader.
- Each request is accepted with a valid/ready handshake, chosen by round-robin priority, and executed on the ALU for one cycle.
- The result is held in a response register until the consumer takes it.
- Sits between the PE operand routing and the ALU instance. It drives the ALU enable, opcode and operand inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must equal ceil(log2(NREQ)).
- DW, 32, operand/result width; matches the ALU datapath.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_op  in  4*NREQ  opcode per requester; slice i = [4i+3:4i], same encoding as ALU instruction[18:15].
- req_a  in  DW*NREQ  operand 1 per requester.
- req_b  in  DW*NREQ  operand 2 per requester.
- alu_en  out  1  ALU enable.
- alu_op  out  4  ALU opcode.
- alu_in1  out  DW  ALU operand 1.
- alu_in2  out  DW  ALU operand 2.
- alu_out  in  DW  ALU result, combinational from alu_* outputs.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that issued the op.
- rsp_data  out  DW  result.
- rsp_err  out  1  opcode was illegal (1000..1111).

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, alu_en=0, alu_op=0, alu_in1=0, alu_in2=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - Reset mid-operation discards the in-flight op and any pending response; no response is ever emitted for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick grant g = first set bit searching rr_ptr, rr_ptr+1, ... with wrap mod NREQ.
  - req_ready[g]=1 combinationally in this cycle; the handshake completes here.
  - Latch req_op[g], req_a[g], req_b[g] and g into the operand registers; next state is EXEC.
  - rr_ptr <= (g+1) mod NREQ.
  - If no req_valid is high, stay in IDLE and leave rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_op, alu_in1 and alu_in2 are driven from the latched registers.
  - Legal op (0000..0111): alu_en=1; rsp_data <= alu_out, rsp_err <= 0.
  - Illegal op: alu_en=0; rsp_data <= 0, rsp_err <= 1.
  - rsp_id <= latched g; rsp_valid <= 1; next state is RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid <= 0; next state is IDLE.
  - No new request is accepted in RESP.
- alu_en is low in IDLE and RESP. alu_op, alu_in1 and alu_in2 keep their last latched values in those states.
- req_ready is 0 in EXEC and RESP.
- Latency:
  - Accept at cycle T; rsp_valid rises at the T+2 edge.
  - Minimum issue interval is 3 cycles with rsp_ready tied high.
- Fairness:
  - A continuously asserted requester is granted within NREQ grants.
  - Request inputs are sampled only at the IDLE accept.
  - A requester may drop valid at any time before being granted.
- Arithmetic: the block passes operands and the result unchanged. Width and overflow behaviour is defined by the ALU, e.g. add wraps mod 2^DW.
- Simultaneous events:
  - All requesters valid at once → grant goes to rr_ptr.
  - rsp_ready high during EXEC has no effect; it takes effect only in RESP.

Test Plan:
- Reset → all outputs 0, state IDLE; assert rst_n low mid-EXEC → rsp_valid stays 0 and rr_ptr returns to 0.
- Single request: req 1 op=0000, a=5, b=7, rsp_ready=1 → req_ready[1] high in the accept cycle; rsp_valid=1 two edges later with rsp_id=1, rsp_data=12, rsp_err=0.
- All 4 requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0. Ops per requester:
  - req0 sub: 10-3 → 7.
  - req1 mul: 3*4 → 12.
  - req2 shl: 1<<4 → 16.
  - req3 cmp<: 2<5 → 1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp fields stable, req_ready all 0; when rsp_ready=1, the next accept happens the cycle after the handshake.
- Illegal op 1010 from req 2 → alu_en never asserted; response rsp_err=1, rsp_data=0, rsp_id=2.
- Grants from rr_ptr=3 with only reqs 0 and 1 valid → grant goes to 0, then to 1.
